// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down counter with modulus, wrap or
// saturate at the boundaries, synchronous parallel load, a terminal-count
// prediction, and sticky overflow and load-error flags.
module counter_updown_mod #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter bit     SATURATE  = 1'b0,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero,
    output logic             ovf,
    output logic             load_err
);

    // Parameter legality is checked at elaboration so an illegal instance
    // never reaches synthesis.
    if (WIDTH < 1 || WIDTH > 32) begin : g_badWidth
        $error("counter_updown_mod: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_badModulus
        $error("counter_updown_mod: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_badResetVal
        $error("counter_updown_mod: RESET_VAL must be below MODULUS");
    end

    // The top count value and the modulus are both held in wide form.
    // The top value then fits WIDTH bits even when MODULUS is 2**WIDTH.
    // The range check on load_val is done in 64 bits for the same reason.
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VAL);
    localparam logic [63:0]      MOD_WIDE  = 64'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_loadErr;

    logic             w_atMax;
    logic             w_atZero;
    logic             w_boundary;
    logic             w_loadInRange;
    logic             w_boundaryEvent;
    logic [WIDTH-1:0] w_stepVal;
    logic [WIDTH-1:0] w_loadVal;

    assign w_atMax         = (r_count == MAX_VAL);
    assign w_atZero        = (r_count == '0);
    assign w_boundary      = up_dn ? w_atMax : w_atZero;
    assign w_loadInRange   = (64'(load_val) < MOD_WIDE);
    assign w_boundaryEvent = enable & ~load & w_boundary;
    assign w_loadVal       = w_loadInRange ? load_val : MAX_VAL;

    // Next value for one counting step.
    // At a boundary it either wraps to the opposite end or holds in place.
    always_comb begin
        w_stepVal = r_count;
        if (up_dn) begin
            if (!w_atMax) begin
                w_stepVal = r_count + WIDTH'(1);
            end else if (SATURATE) begin
                w_stepVal = MAX_VAL;
            end else begin
                w_stepVal = '0;
            end
        end else begin
            if (!w_atZero) begin
                w_stepVal = r_count - WIDTH'(1);
            end else if (SATURATE) begin
                w_stepVal = '0;
            end else begin
                w_stepVal = MAX_VAL;
            end
        end
    end

    // Count register. Reset has priority over load, and load over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= w_loadVal;
        end else if (enable) begin
            r_count <= w_stepVal;
        end
    end

    // Sticky overflow flag. A boundary event on an edge outranks a clear
    // requested on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_boundaryEvent | (r_ovf & ~clr_ovf);
        end
    end

    // Load-error pulse. It is high for the single cycle after an
    // out-of-range load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_loadErr <= 1'b0;
        end else begin
            r_loadErr <= load & ~w_loadInRange;
        end
    end

    assign count    = r_count;
    assign ovf      = r_ovf;
    assign load_err = r_loadErr;
    assign zero     = w_atZero;
    assign tc       = enable & w_boundary;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: drives three counter instances from one shared
// stimulus stream and checks each one against an integer reference model.
// The three instances are:
//   A: 16 states, wrap
//   B: 10 states, wrap
//   C: 10 states, saturate, reset value 5
module tb_counter_updown_mod;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;

    logic [3:0] cntV [3];
    logic [2:0] tcV;
    logic [2:0] zeroV;
    logic [2:0] ovfV;
    logic [2:0] lerrV;

    int errors;
    int checks;

    // Reference model state, one slot per instance.
    int mMod [3] = '{16, 10, 10};
    bit mSat [3] = '{1'b0, 1'b0, 1'b1};
    int mRv  [3] = '{0, 0, 5};
    int mCnt [3];
    bit mOvf [3];
    bit mLerr[3];

    counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VAL(0)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cntV[0]), .tc(tcV[0]),
        .zero(zeroV[0]), .ovf(ovfV[0]), .load_err(lerrV[0]));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) dutB (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cntV[1]), .tc(tcV[1]),
        .zero(zeroV[1]), .ovf(ovfV[1]), .load_err(lerrV[1]));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(5)) dutC (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cntV[2]), .tc(tcV[2]),
        .zero(zeroV[2]), .ovf(ovfV[2]), .load_err(lerrV[2]));

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: one count step, with a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance the model by one edge, using the spec rules on integers.
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mCnt[i]  = mRv[i];
                mOvf[i]  = 1'b0;
                mLerr[i] = 1'b0;
            end else if (load) begin
                if (int'(load_val) < mMod[i]) begin
                    mCnt[i]  = int'(load_val);
                    mLerr[i] = 1'b0;
                end else begin
                    mCnt[i]  = mMod[i] - 1;
                    mLerr[i] = 1'b1;
                end
                if (clr_ovf) mOvf[i] = 1'b0;
            end else begin
                bit hit;
                hit      = 1'b0;
                mLerr[i] = 1'b0;
                if (enable) begin
                    if (up_dn) begin
                        if (mCnt[i] + 1 >= mMod[i]) begin
                            hit = 1'b1;
                            mCnt[i] = mSat[i] ? mMod[i] - 1 : 0;
                        end else begin
                            mCnt[i] = mCnt[i] + 1;
                        end
                    end else begin
                        if (mCnt[i] - 1 < 0) begin
                            hit = 1'b1;
                            mCnt[i] = mSat[i] ? 0 : mMod[i] - 1;
                        end else begin
                            mCnt[i] = mCnt[i] - 1;
                        end
                    end
                end
                mOvf[i] = hit || (mOvf[i] && !clr_ovf);
            end
        end
    endtask

    // Compare every instance with the model. The expected outputs are
    // packed as {count, tc, zero, ovf, load_err}.
    task automatic compareModel();
        for (int i = 0; i < 3; i++) begin
            bit expTc;
            int expVec;
            int actVec;
            expTc  = enable && ((up_dn && mCnt[i] == mMod[i] - 1) || (!up_dn && mCnt[i] == 0));
            expVec = (mCnt[i] << 4) | (int'(expTc) << 3) | (int'(mCnt[i] == 0) << 2)
                   | (int'(mOvf[i]) << 1) | int'(mLerr[i]);
            actVec = (int'(cntV[i]) << 4) | (int'(tcV[i]) << 3) | (int'(zeroV[i]) << 2)
                   | (int'(ovfV[i]) << 1) | int'(lerrV[i]);
            checkOutput($sformatf("model%0d", i), actVec, expVec);
        end
    endtask

    // Drive one edge's inputs, step the model, then sample 1 unit after the edge.
    task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l,
                                 input int lv, input bit c);
        reset    = r;
        enable   = e;
        up_dn    = u;
        load     = l;
        load_val = 4'(lv);
        clr_ovf  = c;
        modelStep();
        @(posedge clk);
        #1;
        compareModel();
    endtask

    typedef struct {
        bit       rst;
        bit       en;
        bit       up;
        bit       ld;
        int       lv;
        bit       clr;
        int       reps;
        int       eCnt;
        bit       eTc;
        bit       eZero;
        bit       eOvf;
        bit       eLerr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        up_dn    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        clr_ovf  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mCnt[i]  = 0;
            mOvf[i]  = 1'b0;
            mLerr[i] = 1'b0;
        end

        // Table entries, with expected values given for instance A only.
        // Fields: rst en up ld lv clr reps | count tc zero ovf load_err
        vecs[0]  = '{1, 0, 0, 0,  0, 0,  1,  0, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 1, 0,  0, 0, 10, 10, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0,  0, 0,  5, 10, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 0,  0, 0,  5, 15, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 0,  0, 0,  1,  0, 0, 1, 1, 0};
        vecs[5]  = '{0, 0, 1, 0,  0, 1,  1,  0, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 0, 0,  0, 0,  1, 15, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 1,  3, 0,  1,  3, 0, 0, 1, 0};
        vecs[8]  = '{0, 1, 0, 0,  0, 1,  1,  2, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 1, 15, 0,  1, 15, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 1, 0,  0, 1,  1,  0, 0, 1, 1, 0};
        vecs[11] = '{1, 1, 0, 1,  7, 0,  1,  0, 1, 1, 0, 0};

        @(posedge clk);
        #1;

        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < vecs[v].reps; k++) begin
                applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].up, vecs[v].ld,
                              vecs[v].lv, vecs[v].clr);
            end
            checkOutput($sformatf("vec%0d.count", v), int'(cntV[0]), vecs[v].eCnt);
            checkOutput($sformatf("vec%0d.tc", v),    int'(tcV[0]),  int'(vecs[v].eTc));
            checkOutput($sformatf("vec%0d.zero", v),  int'(zeroV[0]), int'(vecs[v].eZero));
            checkOutput($sformatf("vec%0d.ovf", v),   int'(ovfV[0]), int'(vecs[v].eOvf));
            checkOutput($sformatf("vec%0d.lerr", v),  int'(lerrV[0]), int'(vecs[v].eLerr));
        end

        // Instance B, 10 states with wrap: step down through zero, clear
        // the flag, then count down to zero again.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("B.downWrap.count", int'(cntV[1]), 9);
        checkOutput("B.downWrap.ovf",   int'(ovfV[1]), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("B.clr.ovf", int'(ovfV[1]), 0);
        for (int k = 0; k < 9; k++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("B.down9.count", int'(cntV[1]), 0);
        checkOutput("B.down9.zero",  int'(zeroV[1]), 1);
        checkOutput("B.down9.ovf",   int'(ovfV[1]), 0);

        // Instance C, 10 states with saturation: hold at the top, then
        // check set-dominance, load error, and reset beating load.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("C.reset.count", int'(cntV[2]), 5);
        applyStimulus(0, 0, 1, 1, 8, 0);
        checkOutput("C.load8.count", int'(cntV[2]), 8);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("C.up1.count", int'(cntV[2]), 9);
        checkOutput("C.up1.ovf",   int'(ovfV[2]), 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("C.sat.count", int'(cntV[2]), 9);
        checkOutput("C.sat.ovf",   int'(ovfV[2]), 1);
        checkOutput("C.sat.tc",    int'(tcV[2]), 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("C.setDominant.ovf", int'(ovfV[2]), 1);
        applyStimulus(0, 0, 1, 1, 12, 0);
        checkOutput("C.badLoad.count", int'(cntV[2]), 9);
        checkOutput("C.badLoad.lerr",  int'(lerrV[2]), 1);
        checkOutput("B.badLoad.count", int'(cntV[1]), 9);
        checkOutput("B.badLoad.lerr",  int'(lerrV[1]), 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("C.lerrPulse.lerr", int'(lerrV[2]), 0);
        applyStimulus(0, 1, 1, 1, 3, 0);
        checkOutput("C.loadOverEn.count", int'(cntV[2]), 3);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("C.to7.count", int'(cntV[2]), 7);
        checkOutput("C.to7.ovf",   int'(ovfV[2]), 1);
        applyStimulus(1, 1, 1, 1, 2, 0);
        checkOutput("C.resetWins.count", int'(cntV[2]), 5);
        checkOutput("C.resetWins.ovf",   int'(ovfV[2]), 0);
        checkOutput("C.resetWins.lerr",  int'(lerrV[2]), 0);

        // Random traffic on all instances, checked against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom % 32) == 0, ($urandom % 4) != 0, $urandom_range(0, 1) == 1,
                          ($urandom % 8) == 0, int'($urandom_range(0, 15)),
                          ($urandom % 8) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the team's 4-bit enable counter.
- Adds configurable width and modulus, up/down direction, synchronous parallel load, and a wrap-or-saturate mode.
- Adds terminal-count and sticky overflow flags.
- Used as a general event/tick counter in datapath and timer logic; one instance per counted channel.

Parameters:
- WIDTH, 4, count register width in bits (1..32).
- MODULUS, 16, number of count states; count range 0..MODULUS-1. Legal range 2..2^WIDTH; elaboration error otherwise.
- SATURATE, 0, 0 = wrap at boundary; 1 = hold at boundary.
- RESET_VAL, 0, count value after reset. Must be < MODULUS; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  count by one step on this edge when high
- up_dn  input  1  1 = count up, 0 = count down; sampled only when enable=1
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- clr_ovf  input  1  clears sticky overflow flag
- count  output  WIDTH  registered count value
- tc  output  1  combinational terminal count: enable=1 and count is at the boundary in the current direction
- zero  output  1  combinational: count == 0
- ovf  output  1  registered sticky flag: set on any boundary crossing attempt
- load_err  output  1  registered one-cycle pulse: previous edge loaded an out-of-range value

Behaviour:
- Single clock domain; all state updates on rising clk.
- Reset is synchronous and active-high. reset=1 at an edge sets:
  - count=RESET_VAL, ovf=0, load_err=0.
  - reset overrides load, enable and clr_ovf on the same edge.
- Priority per edge: reset > load > enable. load=1 with enable=1 loads and does not count.
- Load:
  - load_val < MODULUS: count=load_val, load_err=0.
  - load_val >= MODULUS: count=MODULUS-1, load_err=1 for exactly one cycle.
  - Load never sets ovf.
- Count, enable=1 and load=0:
  - up_dn=1, count < MODULUS-1: count+1.
  - up_dn=0, count > 0: count-1.
  - Boundary going up (count==MODULUS-1): SATURATE=0 gives 0; SATURATE=1 holds MODULUS-1.
  - Boundary going down (count==0): SATURATE=0 gives MODULUS-1; SATURATE=1 holds 0.
  - Any boundary case sets ovf=1, in both modes.
- enable=0 and load=0: count holds; ovf holds unless cleared.
- ovf:
  - Set-dominant. A boundary event and clr_ovf on the same edge leaves ovf=1.
  - clr_ovf alone clears ovf to 0 on that edge.
- tc: high in the same cycle as the boundary state when enable=1. It predicts the wrap/hold on the next edge and is low when enable=0.
- zero: reflects the registered count only; independent of enable.
- Arithmetic: increment/decrement carried out in WIDTH bits. MODULUS == 2^WIDTH must work with no truncation error in the MODULUS-1 comparison.
- Latency: count, ovf and load_err change one edge after the inputs are sampled; tc and zero are combinational from registers and inputs.
- Reset mid-count: takes effect on the next edge regardless of enable or load; the following edge resumes normal operation.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Default params: reset, then enable=1, up_dn=1 for 10 edges -> count=10, tc=0, ovf=0. After 15 edges total -> count=15, tc=1. Edge 16 -> count=0, ovf=1, zero=1.
- enable=0 for 5 edges from count=10 -> count stays 10, tc=0. Re-enable for 5 edges -> count=15.
- MODULUS=10, SATURATE=0: reset, then up_dn=0, enable=1 for one edge -> count=9, ovf=1. clr_ovf pulse -> ovf=0. 9 more down edges -> count=0, zero=1.
- MODULUS=10, SATURATE=1: load_val=8, then 5 up edges -> count=9 held after edge 1, ovf=1. clr_ovf asserted on the same edge as a boundary step -> ovf stays 1.
- MODULUS=10: load=1, load_val=12 -> count=9, load_err=1 for one cycle, then 0. load=1 and enable=1 with load_val=3 -> count=3, no increment.
- RESET_VAL=5: count to 7, then assert reset together with load=1, load_val=2 and clr_ovf=0 while ovf=1 -> count=5, ovf=0, load_err=0 on that edge.
